// File: rtl/gated_clk_pkg.sv
// Shared state encoding and default sizing for the multi-channel clock-gating controller.
// Holds no logic, so it adds no latency and applies no backpressure.
package gated_clk_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } ch_state_e;

  localparam int DEF_IDLE_W   = 8;
  localparam int DEF_WAKE_DLY = 2;

endpackage

// File: rtl/gated_clk_ch.sv
// One gated-clock channel: OFF/WAKE/ON/IDLE FSM, wake and idle counters, and a 4-phase ack register.
// Enable rises one edge after activity and ack follows WAKE_DLY edges later; there is no backpressure.
module gated_clk_ch
  import gated_clk_pkg::*;
#(
  parameter int IDLE_W   = DEF_IDLE_W,
  parameter int WAKE_DLY = DEF_WAKE_DLY
) (
  input  logic              clk_in,
  input  logic              rst_b,
  input  logic              global_en,
  input  logic [IDLE_W-1:0] idle_thresh,
  input  logic              busy,
  input  logic              wake_req,
  output logic              wake_ack,
  output logic              clk_en_st,
  output logic              gated
);

  localparam int WAKE_W = (WAKE_DLY > 1) ? $clog2(WAKE_DLY) : 1;
  localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_DLY - 1);

  ch_state_e         state_q, state_d;
  logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              ack_q, ack_d;
  logic              en_q, en_d;
  logic              gated_q, gated_d;
  logic              act;

  assign act = busy | wake_req;

  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    idle_cnt_d = idle_cnt_q;
    if (!global_en) begin
      state_d    = ST_OFF;
      wake_cnt_d = '0;
      idle_cnt_d = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (act) begin
            state_d    = ST_WAKE;
            wake_cnt_d = WAKE_LOAD;
          end
        end
        ST_WAKE: begin
          // Activity dropping here is ignored: a started wake always completes.
          if (wake_cnt_q == '0) state_d = ST_ON;
          else                  wake_cnt_d = wake_cnt_q - WAKE_W'(1);
        end
        ST_ON: begin
          if (!act) begin
            state_d    = ST_IDLE;
            idle_cnt_d = idle_thresh;
          end
        end
        ST_IDLE: begin
          if (act) begin
            state_d    = ST_ON;
            idle_cnt_d = '0;
          end else if (idle_cnt_q == '0) begin
            state_d = ST_OFF;
          end else begin
            idle_cnt_d = idle_cnt_q - IDLE_W'(1);
          end
        end
        default: state_d = ST_OFF;
      endcase
    end

    ack_d   = ((state_d == ST_ON) || (state_d == ST_IDLE)) && wake_req;
    en_d    = (state_d != ST_OFF);
    gated_d = (state_d == ST_OFF);
  end

  always_ff @(posedge clk_in or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= ST_OFF;
      wake_cnt_q <= '0;
      idle_cnt_q <= '0;
      ack_q      <= 1'b0;
      en_q       <= 1'b0;
      gated_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      ack_q      <= ack_d;
      en_q       <= en_d;
      gated_q    <= gated_d;
    end
  end

  assign wake_ack  = ack_q;
  assign clk_en_st = en_q;
  assign gated     = gated_q;

endmodule

// File: rtl/gated_clk_ctrl.sv
// Multi-channel clock-gating controller: per-channel FSMs plus global disable and test/scan override.
// Enables are registered except the override OR, which is combinational; there is no backpressure.
module gated_clk_ctrl
  import gated_clk_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int IDLE_W   = DEF_IDLE_W,
  parameter int WAKE_DLY = DEF_WAKE_DLY
) (
  input  logic              clk_in,
  input  logic              rst_b,
  input  logic              global_en,
  input  logic              pad_yy_test_mode,
  input  logic              pad_yy_gate_clk_en_b,
  input  logic [IDLE_W-1:0] idle_thresh,
  input  logic [NUM_CH-1:0] ch_busy,
  input  logic [NUM_CH-1:0] ch_wake_req,
  output logic [NUM_CH-1:0] ch_wake_ack,
  output logic [NUM_CH-1:0] ch_clk_en,
  output logic [NUM_CH-1:0] ch_gated
);

  logic [NUM_CH-1:0] st_en;
  logic              force_on;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    gated_clk_ch #(
      .IDLE_W   (IDLE_W),
      .WAKE_DLY (WAKE_DLY)
    ) u_ch (
      .clk_in      (clk_in),
      .rst_b       (rst_b),
      .global_en   (global_en),
      .idle_thresh (idle_thresh),
      .busy        (ch_busy[i]),
      .wake_req    (ch_wake_req[i]),
      .wake_ack    (ch_wake_ack[i]),
      .clk_en_st   (st_en[i]),
      .gated       (ch_gated[i])
    );
  end

  // Override bypasses the FSMs so scan sees running clocks even in reset.
  assign force_on  = pad_yy_test_mode | pad_yy_gate_clk_en_b;
  assign ch_clk_en = st_en | {NUM_CH{force_on}};

endmodule

// File: tb/tb_gated_clk_ctrl.sv
// Directed self-checking bench for gated_clk_ctrl (NUM_CH=4, IDLE_W=8, WAKE_DLY=2).
module tb_gated_clk_ctrl;

  logic       clk_in;
  logic       rst_b;
  logic       global_en;
  logic       pad_yy_test_mode;
  logic       pad_yy_gate_clk_en_b;
  logic [7:0] idle_thresh;
  logic [3:0] ch_busy;
  logic [3:0] ch_wake_req;
  logic [3:0] ch_wake_ack;
  logic [3:0] ch_clk_en;
  logic [3:0] ch_gated;

  int errors = 0;
  int checks = 0;

  gated_clk_ctrl #(
    .NUM_CH   (4),
    .IDLE_W   (8),
    .WAKE_DLY (2)
  ) dut (
    .clk_in               (clk_in),
    .rst_b                (rst_b),
    .global_en            (global_en),
    .pad_yy_test_mode     (pad_yy_test_mode),
    .pad_yy_gate_clk_en_b (pad_yy_gate_clk_en_b),
    .idle_thresh          (idle_thresh),
    .ch_busy              (ch_busy),
    .ch_wake_req          (ch_wake_req),
    .ch_wake_ack          (ch_wake_ack),
    .ch_clk_en            (ch_clk_en),
    .ch_gated             (ch_gated)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_b                = 1'b0;
    global_en            = 1'b1;
    pad_yy_test_mode     = 1'b0;
    pad_yy_gate_clk_en_b = 1'b0;
    idle_thresh          = 8'd3;
    ch_busy              = 4'h0;
    ch_wake_req          = 4'h0;

    // 1: reset state and quiescent behaviour
    #7;
    chk("rst_en",    ch_clk_en,   4'h0);
    chk("rst_gated", ch_gated,    4'hF);
    chk("rst_ack",   ch_wake_ack, 4'h0);
    #5 rst_b = 1'b1;
    repeat (5) tick();
    chk("quiet_en",    ch_clk_en,   4'h0);
    chk("quiet_gated", ch_gated,    4'hF);
    chk("quiet_ack",   ch_wake_ack, 4'h0);
    pad_yy_gate_clk_en_b = 1'b1;
    #1;
    chk("gdis_en",    ch_clk_en, 4'hF);
    chk("gdis_gated", ch_gated,  4'hF);
    pad_yy_gate_clk_en_b = 1'b0;
    #1;
    chk("gdis_off_en", ch_clk_en, 4'h0);

    // 2: wake handshake on channel 1
    ch_wake_req = 4'b0010;
    tick();
    chk("wake_n_en",    ch_clk_en,   4'b0010);
    chk("wake_n_gated", ch_gated,    4'b1101);
    chk("wake_n_ack",   ch_wake_ack, 4'h0);
    tick();
    chk("wake_n1_ack",  ch_wake_ack, 4'h0);
    tick();
    chk("wake_n2_ack",  ch_wake_ack, 4'b0010);
    ch_wake_req = 4'h0;
    tick();
    chk("wake_fall_ack", ch_wake_ack, 4'h0);
    chk("wake_fall_en",  ch_clk_en,   4'b0010);
    repeat (3) tick();
    chk("wake_idle_hold", ch_clk_en, 4'b0010);
    tick();
    chk("wake_idle_off",  ch_clk_en, 4'h0);

    // 3: idle hold-off of 3 on channel 0, then busy re-assert mid-IDLE
    ch_busy = 4'b0001;
    repeat (3) tick();
    chk("on_gated", ch_gated, 4'b1110);
    ch_busy = 4'h0;
    tick();
    chk("idle_m_en", ch_clk_en, 4'b0001);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("idle_hold_en", ch_clk_en, 4'b0001);
    end
    tick();
    chk("idle_m4_en",    ch_clk_en, 4'h0);
    chk("idle_m4_gated", ch_gated,  4'hF);

    ch_busy = 4'b0001;
    repeat (3) tick();
    ch_busy = 4'h0;
    tick();
    tick();
    ch_busy = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rebusy_en", ch_clk_en, 4'b0001);
    end
    chk("rebusy_gated", ch_gated, 4'b1110);
    ch_busy = 4'h0;
    repeat (5) tick();
    chk("rebusy_off", ch_gated, 4'hF);

    // 4: threshold extremes; threshold is sampled only on IDLE entry
    idle_thresh = 8'd0;
    ch_busy = 4'b0001;
    repeat (3) tick();
    ch_busy = 4'h0;
    tick();
    chk("thr0_m_en",  ch_clk_en, 4'b0001);
    tick();
    chk("thr0_m1_en", ch_clk_en, 4'h0);

    idle_thresh = 8'hFF;
    ch_busy = 4'b0001;
    repeat (3) tick();
    ch_busy = 4'h0;
    tick();
    idle_thresh = 8'd0;
    repeat (255) tick();
    chk("thrff_m255_en",  ch_clk_en, 4'b0001);
    tick();
    chk("thrff_m256_en",  ch_clk_en, 4'h0);
    idle_thresh = 8'd3;

    // 5: global_en pulse with test mode override
    ch_busy = 4'hF;
    ch_wake_req = 4'hF;
    repeat (3) tick();
    chk("all_on_ack",   ch_wake_ack, 4'hF);
    chk("all_on_gated", ch_gated,    4'h0);
    global_en = 1'b0;
    pad_yy_test_mode = 1'b1;
    tick();
    chk("gen_off_gated", ch_gated,    4'hF);
    chk("gen_off_ack",   ch_wake_ack, 4'h0);
    chk("gen_off_en",    ch_clk_en,   4'hF);
    pad_yy_test_mode = 1'b0;
    #1;
    chk("tm_drop_en", ch_clk_en, 4'h0);
    global_en = 1'b1;
    tick();
    chk("gen_back_gated", ch_gated,    4'h0);
    chk("gen_back_ack",   ch_wake_ack, 4'h0);
    chk("gen_back_en",    ch_clk_en,   4'hF);
    repeat (2) tick();
    chk("gen_rewake_ack", ch_wake_ack, 4'hF);
    ch_busy = 4'h0;
    ch_wake_req = 4'h0;
    tick();
    chk("all_fall_ack", ch_wake_ack, 4'h0);
    repeat (4) tick();
    chk("all_idle_off", ch_gated, 4'hF);

    // 6: asynchronous reset mid-WAKE and after ack on channel 2
    ch_wake_req = 4'b0100;
    tick();
    chk("ch2_wake_en", ch_clk_en, 4'b0100);
    #2 rst_b = 1'b0;
    #1;
    chk("arst_wake_en",    ch_clk_en,   4'h0);
    chk("arst_wake_gated", ch_gated,    4'hF);
    chk("arst_wake_ack",   ch_wake_ack, 4'h0);
    tick();
    rst_b = 1'b1;
    tick();
    chk("rewake_en", ch_clk_en, 4'b0100);
    repeat (2) tick();
    chk("rewake_ack", ch_wake_ack, 4'b0100);
    #2 rst_b = 1'b0;
    #1;
    chk("arst_on_ack", ch_wake_ack, 4'h0);
    chk("arst_on_en",  ch_clk_en,   4'h0);
    rst_b = 1'b1;
    ch_wake_req = 4'h0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
